// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ALU opcodes and E/M bubble values for the pipeline
package pipe_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_REG_AW = 5;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR = 2'b11;
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic BUBBLE_DM_WRITE = 1'b0;
  localparam logic BUBBLE_RESULT = 1'b0;
  localparam logic BUBBLE_RF_WE = 1'b0;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/and/or with signed overflow flag
module alu
  import pipe_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] y,
  output logic            ovf
);
  // result mux and overflow; overflow only meaningful for add/sub
  always_comb begin
    y = op == ALU_ADD ? a + b : op == ALU_SUB ? a - b : op == ALU_AND ? a & b : a | b;
    ovf = op == ALU_ADD ? (a[XLEN-1] == b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]) :
          op == ALU_SUB ? (a[XLEN-1] != b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]) : 1'b0;
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU stage plus E/M pipeline register; EXEC_FWD_EN adds M/W operand forwarding
module execute_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EXEC_FWD_EN
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RF_WE_W,
  input  logic [XLEN-1:0]   Result_W,
`endif
  input  logic              Valid_E,
  input  logic              Stall_E,
  input  logic              Flush_E,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Extend_E,
  input  logic [1:0]        Alu_op_E,
  input  logic              Alu_src_E,
  input  logic              DM_Write_E,
  input  logic              Result_E,
  input  logic              RF_WE_E,
  input  logic [REG_AW-1:0] Rd_E,
  output logic [XLEN-1:0]   ALU_Result_M,
  output logic [XLEN-1:0]   WD_M,
  output logic [REG_AW-1:0] Rd_M,
  output logic              DM_Write_M,
  output logic              Result_M,
  output logic              RF_WE_M,
  output logic              Valid_M,
  output logic              Zero_M,
  output logic              Ovf_M
);
  logic [XLEN-1:0] a, rd2, b, y;
  logic ovf;
`ifdef EXEC_FWD_EN
  logic m_fwd, m_hit1, m_hit2, w_hit1, w_hit2;
  // M stage forwards only ALU results (loads are stalled externally); M beats W
  always_comb begin
    m_fwd = RF_WE_M && Valid_M && !Result_M && Rd_M != '0;
    m_hit1 = m_fwd && Rd_M == Rs1_E;
    m_hit2 = m_fwd && Rd_M == Rs2_E;
    w_hit1 = RF_WE_W && Rd_W != '0 && Rd_W == Rs1_E;
    w_hit2 = RF_WE_W && Rd_W != '0 && Rd_W == Rs2_E;
    a = m_hit1 ? ALU_Result_M : w_hit1 ? Result_W : RD1_E;
    rd2 = m_hit2 ? ALU_Result_M : w_hit2 ? Result_W : RD2_E;
    b = Alu_src_E ? Extend_E : rd2;
  end
`else
  // operands straight from the D/E register
  always_comb begin
    a = RD1_E;
    rd2 = RD2_E;
    b = Alu_src_E ? Extend_E : rd2;
  end
`endif
  alu #(.XLEN(XLEN)) u_alu (
    .a  (a),
    .b  (b),
    .op (Alu_op_E),
    .y  (y),
    .ovf(ovf)
  );
  // E/M register: reset/flush insert a bubble, stall holds, invalid input loads a bubble
  always_ff @(posedge clk) begin
    if (rst || Flush_E || (!Stall_E && !Valid_E)) begin
      ALU_Result_M <= '0;
      WD_M <= '0;
      Rd_M <= '0;
      DM_Write_M <= BUBBLE_DM_WRITE;
      Result_M <= BUBBLE_RESULT;
      RF_WE_M <= BUBBLE_RF_WE;
      Valid_M <= BUBBLE_VALID;
      Zero_M <= 1'b0;
      Ovf_M <= 1'b0;
    end else if (!Stall_E) begin
      ALU_Result_M <= y;
      WD_M <= rd2;
      Rd_M <= Rd_E;
      DM_Write_M <= DM_Write_E;
      Result_M <= Result_E;
      RF_WE_M <= RF_WE_E;
      Valid_M <= 1'b1;
      Zero_M <= y == '0;
      Ovf_M <= ovf;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table-driven directed checks of execute_stage (EXEC_FWD_EN adds forwarding cases)
module tb_execute_stage;
  typedef struct packed {
    logic        valid, stall, flush;
    logic [31:0] rd1, rd2, ext;
    logic [1:0]  op;
    logic        src, dmw, res, rfwe;
    logic [4:0]  rd;
    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_rd;
    logic        e_dmw, e_res, e_rfwe, e_valid, e_zero, e_ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic Valid_E, Stall_E, Flush_E, Alu_src_E, DM_Write_E, Result_E, RF_WE_E;
  logic [31:0] RD1_E, RD2_E, Extend_E;
  logic [1:0] Alu_op_E;
  logic [4:0] Rd_E;
  logic [31:0] ALU_Result_M, WD_M;
  logic [4:0] Rd_M;
  logic DM_Write_M, Result_M, RF_WE_M, Valid_M, Zero_M, Ovf_M;
`ifdef EXEC_FWD_EN
  logic [4:0] Rs1_E, Rs2_E, Rd_W;
  logic RF_WE_W;
  logic [31:0] Result_W;
`endif
  int total = 0;
  int bad = 0;
  vec_t tv [15];
  localparam logic [74:0] ZERO_OUT = '0;
  always #5 clk = ~clk;
  execute_stage dut (
    .clk(clk), .rst(rst),
`ifdef EXEC_FWD_EN
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_W(Rd_W), .RF_WE_W(RF_WE_W), .Result_W(Result_W),
`endif
    .Valid_E(Valid_E), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Extend_E(Extend_E), .Alu_op_E(Alu_op_E),
    .Alu_src_E(Alu_src_E), .DM_Write_E(DM_Write_E), .Result_E(Result_E),
    .RF_WE_E(RF_WE_E), .Rd_E(Rd_E),
    .ALU_Result_M(ALU_Result_M), .WD_M(WD_M), .Rd_M(Rd_M), .DM_Write_M(DM_Write_M),
    .Result_M(Result_M), .RF_WE_M(RF_WE_M), .Valid_M(Valid_M), .Zero_M(Zero_M), .Ovf_M(Ovf_M)
  );
  task automatic apply(input vec_t v);
    Valid_E = v.valid; Stall_E = v.stall; Flush_E = v.flush;
    RD1_E = v.rd1; RD2_E = v.rd2; Extend_E = v.ext; Alu_op_E = v.op;
    Alu_src_E = v.src; DM_Write_E = v.dmw; Result_E = v.res; RF_WE_E = v.rfwe; Rd_E = v.rd;
`ifdef EXEC_FWD_EN
    Rs1_E = '0; Rs2_E = '0; Rd_W = '0; RF_WE_W = 1'b0; Result_W = '0;
`endif
  endtask
  task automatic check(input string nm, input logic [74:0] exp);
    logic [74:0] act;
    @(posedge clk);
    #1;
    act = {ALU_Result_M, WD_M, Rd_M, DM_Write_M, Result_M, RF_WE_M, Valid_M, Zero_M, Ovf_M};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got alu=%h wd=%h rd=%0d dmw/res/we/v/z/o=%b required alu=%h wd=%h rd=%0d dmw/res/we/v/z/o=%b",
               nm, act[74:43], act[42:11], act[10:6], act[5:0], exp[74:43], exp[42:11], exp[10:6], exp[5:0]);
    end
  endtask
  initial begin
    //            v    st   fl   rd1            rd2            ext            op     src  dmw  res  we   rd       alu            wd             rd       dmw  res  we   val  z    o
    tv[0]  = '{1'b1,1'b0,1'b0,32'h5,        32'h3,        32'h0,        2'b00,1'b0,1'b0,1'b0,1'b1,5'd6,  32'h8,        32'h3,        5'd6,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
    tv[1]  = '{1'b1,1'b0,1'b0,32'h3,        32'h0,        32'h3,        2'b01,1'b1,1'b0,1'b0,1'b1,5'd7,  32'h0,        32'h0,        5'd7,  1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
    tv[2]  = '{1'b1,1'b0,1'b0,32'h80000000, 32'h1,        32'h0,        2'b01,1'b0,1'b0,1'b0,1'b1,5'd8,  32'h7FFFFFFF, 32'h1,        5'd8,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b1};
    tv[3]  = '{1'b1,1'b0,1'b0,32'h7FFFFFFF, 32'h1,        32'h0,        2'b00,1'b0,1'b0,1'b0,1'b1,5'd8,  32'h80000000, 32'h1,        5'd8,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b1};
    tv[4]  = '{1'b1,1'b0,1'b0,32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        2'b10,1'b0,1'b0,1'b0,1'b1,5'd9,  32'h0F0F0000, 32'h0F0F0F0F, 5'd9,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
    tv[5]  = '{1'b1,1'b0,1'b0,32'h1200,     32'h55,       32'h34,       2'b11,1'b1,1'b0,1'b0,1'b1,5'd10, 32'h1234,     32'h55,       5'd10, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
    tv[6]  = '{1'b1,1'b0,1'b0,32'hFFFFFFFF, 32'h1,        32'h0,        2'b00,1'b0,1'b0,1'b0,1'b1,5'd11, 32'h0,        32'h1,        5'd11, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
    tv[7]  = '{1'b0,1'b0,1'b0,32'h0,        32'hDEADBEEF, 32'h0,        2'b00,1'b0,1'b1,1'b0,1'b1,5'd12, 32'h0,        32'h0,        5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[8]  = '{1'b1,1'b0,1'b0,32'h0,        32'hDEADBEEF, 32'h0,        2'b00,1'b0,1'b1,1'b0,1'b0,5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
    tv[9]  = '{1'b1,1'b1,1'b0,32'h1,        32'h2,        32'h3,        2'b01,1'b1,1'b0,1'b1,1'b1,5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
    tv[10] = '{1'b0,1'b1,1'b0,32'h7,        32'h7,        32'h7,        2'b11,1'b0,1'b0,1'b0,1'b1,5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 5'd0,  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
    tv[11] = '{1'b1,1'b1,1'b1,32'h1,        32'h2,        32'h3,        2'b00,1'b0,1'b1,1'b1,1'b1,5'd4,  32'h0,        32'h0,        5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    tv[12] = '{1'b1,1'b0,1'b0,32'h100,      32'h0,        32'h4,        2'b00,1'b1,1'b0,1'b1,1'b1,5'd9,  32'h104,      32'h0,        5'd9,  1'b0,1'b1,1'b1,1'b1,1'b0,1'b0};
    tv[13] = '{1'b1,1'b0,1'b0,32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0,        2'b01,1'b0,1'b0,1'b0,1'b1,5'd1,  32'h80000000, 32'hFFFFFFFF, 5'd1,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b1};
    tv[14] = '{1'b1,1'b0,1'b1,32'h5,        32'h3,        32'h0,        2'b00,1'b0,1'b1,1'b0,1'b1,5'd6,  32'h0,        32'h0,        5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    rst = 1'b1;
    apply(tv[0]);
    check("reset", ZERO_OUT);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      apply(tv[i]);
      check($sformatf("vec%0d", i), {tv[i].e_alu, tv[i].e_wd, tv[i].e_rd, tv[i].e_dmw, tv[i].e_res,
                                      tv[i].e_rfwe, tv[i].e_valid, tv[i].e_zero, tv[i].e_ovf});
    end
    apply(tv[0]);
    check("pre_rst", {32'h8, 32'h3, 5'd6, 6'b001100});
    rst = 1'b1;
    Stall_E = 1'b1;
    apply(tv[5]);
    Stall_E = 1'b1;
    check("mid_rst", ZERO_OUT);
    rst = 1'b0;
    apply(tv[5]);
    check("post_rst", {32'h1234, 32'h55, 5'd10, 6'b001100});
`ifdef EXEC_FWD_EN
    apply(tv[0]);
    check("fwd_src", {32'h8, 32'h3, 5'd6, 6'b001100});
    apply('{1'b1,1'b0,1'b0,32'h0,32'hC,32'h0,2'b10,1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
    Rs1_E = 5'd6;
    check("fwd_m_hit", {32'h8, 32'hC, 5'd0, 6'b001100});
    apply('{1'b1,1'b0,1'b0,32'h0,32'hC,32'h0,2'b10,1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
    Rs1_E = 5'd6; Rd_W = 5'd6; RF_WE_W = 1'b1; Result_W = 32'h7;
    check("fwd_w_hit", {32'h4, 32'hC, 5'd0, 6'b001100});
    apply('{1'b1,1'b0,1'b0,32'hF,32'hF,32'h0,2'b10,1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0,32'h0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
    Rs1_E = 5'd0; Rd_W = 5'd0; RF_WE_W = 1'b1; Result_W = 32'h7;
    check("fwd_x0", {32'hF, 32'hF, 5'd0, 6'b001100});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
